mode_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-bit Qa..Qd schematic counter.
- One synchronous register bank runs in one of several selectable count modes: binary up/down with programmable modulus, Johnson (twisted ring), or one-hot ring.
- Adds enable, synchronous load and a terminal-count flag, so downstream sequencers can cascade or decode it.
- Used as the shared counter/sequencer primitive in the lab datapaths.

---
 rtl/mode_counter_pkg.sv | 14 +
 rtl/gray_conv.sv | 33 +++
 rtl/mode_counter.sv | 115 +++++++++++
 tb/tb_mode_counter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mode_counter_pkg.sv
// Shared definitions for the mode_counter family.
//
// Holds the 2-bit count-mode encodings and the mode_t type used on the
// mode port of mode_counter and by anything that drives it.
package mode_counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BIN     = 2'b00;  // binary up/down, programmable modulus
    localparam mode_t MODE_JOHNSON = 2'b01;  // twisted ring, 2*WIDTH states
    localparam mode_t MODE_RING    = 2'b10;  // one-hot ring, self-correcting
    localparam mode_t MODE_GRAY    = 2'b11;  // Gray code, only with MODE_COUNTER_GRAY_EN

endpackage

// File: rtl/gray_conv.sv
// Combinational binary <-> Gray code converter.
//
// The two directions are independent paths, so one instance can convert
// the current Gray count to binary and, in parallel, convert the stepped
// binary value back to Gray.
//
// Parameters:
//   WIDTH        code width in bits
// Ports:
//   bin          binary value to encode
//   gray_of_bin  Gray encoding of bin
//   gray         Gray value to decode
//   bin_of_gray  binary decoding of gray
module gray_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray_of_bin,
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin_of_gray
);

    assign gray_of_bin = bin ^ (bin >> 1);

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    always_comb begin
        bin_of_gray = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_of_gray[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Multi-mode counter / sequencer primitive.
//
// A single WIDTH-bit register steps in binary (up/down, wrapping at
// MODULUS), Johnson or one-hot ring order, selected by mode. load has
// priority over en; with neither, q holds. tc flags the terminal state of
// the current mode/direction so counters can be cascaded or decoded.
//
// Optional feature: define MODE_COUNTER_GRAY_EN to make mode 11 a full
// 2**WIDTH Gray up/down counter. Without it, mode 11 holds q and tc is 0.
//
// Parameters:
//   WIDTH     counter width in bits (>= 2)
//   MODULUS   binary-mode wrap point, 2 .. 2**WIDTH
// Ports:
//   CLK       rising-edge clock
//   RST_N     asynchronous active-low reset, clears q
//   en        count enable
//   load      synchronous load strobe, overrides en
//   load_val  value loaded when load is high
//   mode      count mode (see mode_counter_pkg)
//   dir       1 = up, 0 = down (binary and Gray modes)
//   q         registered count
//   tc        terminal count, combinational from q, mode, dir, en
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Largest in-range binary value. Any q at or above it wraps to 0 when
    // counting up, which also recovers out-of-range loaded values.
    localparam logic [WIDTH-1:0] MOD_MAX  = WIDTH'(MODULUS - 1);
    // Terminal state for Johnson, ring and Gray-up: only the MSB set.
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] q_next;

`ifdef MODE_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_as_bin;
    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] gray_step;

    assign bin_step = dir ? gray_as_bin + 1'b1 : gray_as_bin - 1'b1;

    gray_conv #(.WIDTH(WIDTH)) u_gray_conv (
        .bin         (bin_step),
        .gray_of_bin (gray_step),
        .gray        (q),
        .bin_of_gray (gray_as_bin)
    );
`endif

    always_comb begin
        // NOTE: q_next is given a value before any branch so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        q_next = q;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            case (mode)
                MODE_BIN: begin
                    if (dir) q_next = (q >= MOD_MAX) ? '0 : q + 1'b1;
                    else     q_next = (q == '0) ? MOD_MAX : q - 1'b1;
                end
                MODE_JOHNSON: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
                // Anything that is not exactly one-hot restarts the ring.
                MODE_RING: q_next = $onehot(q) ? {q[WIDTH-2:0], q[WIDTH-1]}
                                               : WIDTH'(1);
`ifdef MODE_COUNTER_GRAY_EN
                MODE_GRAY: q_next = gray_step;
`else
                MODE_GRAY: q_next = q;
`endif
                default: q_next = q;
            endcase
        end
    end

    always_comb begin
        tc = 1'b0;
        if (en) begin
            case (mode)
                MODE_BIN:     tc = dir ? (q == MOD_MAX) : (q == '0);
                MODE_JOHNSON: tc = (q == MSB_ONLY);
                MODE_RING:    tc = (q == MSB_ONLY);
`ifdef MODE_COUNTER_GRAY_EN
                // bin2gray(2**WIDTH-1) is the MSB alone.
                MODE_GRAY:    tc = dir ? (q == MSB_ONLY) : (q == '0);
`else
                MODE_GRAY:    tc = 1'b0;
`endif
                default:      tc = 1'b0;
            endcase
        end
    end

    // NOTE: the state register uses non-blocking assignment so every flop
    // samples pre-edge values, matching real hardware ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) q <= '0;
        else        q <= q_next;
    end

endmodule

// File: tb/tb_mode_counter.sv
// Directed self-checking bench for mode_counter with WIDTH=4, MODULUS=10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mode_counter;
    import mode_counter_pkg::*;

    logic       CLK;
    logic       RST_N;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [1:0] mode;
    logic       dir;
    logic [3:0] q;
    logic       tc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] johnson_seq [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [3:0] ring_seq    [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [3:0] down_seq    [4] = '{4'h2, 4'h1, 4'h0, 4'h9};
`ifdef MODE_COUNTER_GRAY_EN
    logic [3:0] gray_seq    [4] = '{4'h1, 4'h3, 4'h2, 4'h6};
`endif

    mode_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .dir      (dir),
        .q        (q),
        .tc       (tc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_q(input string tag, input logic [3:0] expected);
        n_checks++;
        assert (q === expected) else begin
            n_fail++;
            $error("FAIL %s: q observed %h expected %h", tag, q, expected);
        end
    endtask

    task automatic check_tc(input string tag, input logic expected);
        n_checks++;
        assert (tc === expected) else begin
            n_fail++;
            $error("FAIL %s: tc observed %b expected %b", tag, tc, expected);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [3:0] exp_q;

        RST_N = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
        mode = MODE_BIN; dir = 1'b1;

        // Asynchronous reset mid-cycle.
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 check_q("async_reset", 4'h0);
        check_tc("reset_tc", 1'b0);
        @(negedge CLK);
        RST_N = 1'b1; en = 1'b1;
        #1 check_q("reset_release", 4'h0);
        check_tc("bin_up_tc_at_0", 1'b0);

        // Binary up, modulus 10: 1..9,0,1,2.
        for (int i = 1; i <= 12; i++) begin
            tick;
            exp_q = 4'(i % 10);
            check_q($sformatf("bin_up_%0d", i), exp_q);
            check_tc($sformatf("bin_up_tc_%0d", i), exp_q == 4'h9);
        end

        // Load beats en, then count down through the wrap.
        dir = 1'b0; load = 1'b1; load_val = 4'h3;
        tick;
        check_q("load_priority", 4'h3);
        check_tc("bin_down_tc_at_3", 1'b0);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_q($sformatf("bin_down_%0d", i), down_seq[i]);
            check_tc($sformatf("bin_down_tc_%0d", i), down_seq[i] == 4'h0);
        end

        // Out-of-range loaded values: up wraps to 0, down decrements.
        load = 1'b1; load_val = 4'hC; dir = 1'b1;
        tick;
        check_q("load_oor", 4'hC);
        load = 1'b0;
        tick;
        check_q("oor_up_wrap", 4'h0);
        load = 1'b1;
        tick;
        load = 1'b0; dir = 1'b0;
        tick;
        check_q("oor_down", 4'hB);

        // Hold with en low; tc gated by en.
        load = 1'b1; load_val = 4'h9; dir = 1'b1;
        tick;
        load = 1'b0; en = 1'b0;
        #1 check_tc("tc_gated_by_en", 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check_q($sformatf("hold_%0d", i), 4'h9);
            check_tc($sformatf("hold_tc_%0d", i), 1'b0);
        end
        en = 1'b1;
        #1 check_tc("tc_en_high_at_9", 1'b1);
        tick;
        check_q("bin_wrap_after_hold", 4'h0);

        // Mode switches continue from the current q.
        load = 1'b1; load_val = 4'h5;
        tick;
        load = 1'b0; mode = MODE_JOHNSON;
        tick;
        check_q("bin_to_johnson", 4'hB);
        mode = MODE_RING;
        tick;
        check_q("johnson_to_ring", 4'h1);

        // Johnson from reset, toggling dir each step.
        RST_N = 1'b0;
        #1 check_q("reset_midop", 4'h0);
        @(negedge CLK);
        RST_N = 1'b1; mode = MODE_JOHNSON;
        for (int i = 0; i < 8; i++) begin
            dir = (i % 2) == 0;
            tick;
            check_q($sformatf("johnson_%0d", i), johnson_seq[i]);
            check_tc($sformatf("johnson_tc_%0d", i), johnson_seq[i] == 4'h8);
        end

        // Ring self-correction from a non-one-hot value.
        mode = MODE_RING; load = 1'b1; load_val = 4'h6;
        tick;
        check_q("ring_load", 4'h6);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_q($sformatf("ring_%0d", i), ring_seq[i]);
            check_tc($sformatf("ring_tc_%0d", i), ring_seq[i] == 4'h8);
        end

        // Mode 11: load always works; stepping depends on the build.
        mode = MODE_GRAY; dir = 1'b1; load = 1'b1; load_val = 4'hA;
        tick;
        check_q("mode11_load", 4'hA);
`ifdef MODE_COUNTER_GRAY_EN
        load_val = 4'h0;
        tick;
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_q($sformatf("gray_%0d", i), gray_seq[i]);
        end
        load = 1'b1; load_val = 4'h8;
        tick;
        load = 1'b0;
        #1 check_tc("gray_up_tc", 1'b1);
        tick;
        check_q("gray_wrap", 4'h0);
`else
        load = 1'b0;
        #1 check_tc("mode11_tc", 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_q($sformatf("mode11_hold_%0d", i), 4'hA);
            check_tc($sformatf("mode11_hold_tc_%0d", i), 1'b0);
        end
`endif

        // Reset across an edge discards an in-flight load.
        mode = MODE_BIN; dir = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'h7;
        #2 RST_N = 1'b0;
        @(negedge CLK);
        check_q("reset_discards_load", 4'h0);
        RST_N = 1'b1; load = 1'b0;
        tick;
        check_q("count_after_reset", 4'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
